vend_dispense_ctrl: RTL

Dispense back-end for the vending machine. It consumes the machine's single-cycle `beverage` strobe and its `change` code, and queues each sale. It then sequences the physical outputs: a cup-drop motor, followed by one pulse of the 0.5-yuan coin hopper per coin of change. Each step is confirmed by a sensor before the next step starts.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_sale_fifo.sv | 48 ++++
 rtl/vend_dispense_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM states, change-code constants and helpers for the dispense back-end
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VEND,
        WAIT_DROP,
        COIN,
        WAIT_COIN,
        FAULT
    } state_t;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_HALF = 2'b01;
    localparam logic [1:0] CHG_ONE  = 2'b10;

    // Number of 0.5-yuan coins owed for a change code; 11 is treated as none
    function automatic logic [1:0] chg_coins(input logic [1:0] chg);
        return (chg == CHG_NONE) ? 2'd0 :
               (chg == CHG_HALF) ? 2'd1 :
               (chg == CHG_ONE)  ? 2'd2 : 2'd0;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vend_sale_fifo.sv
// vend_sale_fifo: queue of pending sales (coin counts); a push while full is taken only alongside a pop
module vend_sale_fifo
    import vend_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [1:0]                 din,
    input  logic                       pop,
    output logic [1:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic                       accepted,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        pop_ok;

    assign count    = wr_ptr - rd_ptr;
    assign full     = count[AW];
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign accepted = push && (!full || pop_ok);
    assign dout     = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accepted) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (accepted) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: sequences cup drop then change coins per queued sale, each step sensor-confirmed.
// Define VEND_DISPENSE_TIMEOUT_EN to enable the sensor timeout and FAULT state.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES   = 8,
    parameter int HOPPER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int QDEPTH         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       beverage,
    input  logic [1:0] change,
    input  logic       vend_sense,
    input  logic       coin_sense,
    input  logic       fault_clr,
    output logic       vend_motor,
    output logic       hopper_pulse,
    output logic       busy,
    output logic       overflow,
    output logic       fault
);

    localparam int CW  = $clog2(max3(MOTOR_CYCLES, HOPPER_CYCLES, TIMEOUT_CYCLES)) + 1;
    localparam int QAW = $clog2(QDEPTH);
    localparam logic [CW-1:0] M_LOAD = CW'(MOTOR_CYCLES - 1);
    localparam logic [CW-1:0] H_LOAD = CW'(HOPPER_CYCLES - 1);
    localparam logic [CW-1:0] T_LOAD = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    coins, coins_nxt;
    logic          pop, q_full, q_empty, q_accepted;
    logic [1:0]    q_dout;
    logic [QAW:0]  q_count, q_count_nxt;

    vend_sale_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (beverage),
        .din      (chg_coins(change)),
        .pop      (pop),
        .dout     (q_dout),
        .full     (q_full),
        .empty    (q_empty),
        .accepted (q_accepted),
        .count    (q_count)
    );

    assign q_count_nxt = q_count + (QAW+1)'(q_accepted) - (QAW+1)'(pop);

    // Next-state, phase/timeout counter and coin bookkeeping
    always_comb begin
        nxt       = state;
        cnt_nxt   = cnt;
        coins_nxt = coins;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty) begin
                    pop       = 1'b1;
                    coins_nxt = q_dout;
                    cnt_nxt   = M_LOAD;
                    nxt       = VEND;
                end
            end
            VEND: begin
                if (cnt == '0) begin
                    nxt     = WAIT_DROP;
                    cnt_nxt = T_LOAD;
                end else cnt_nxt = cnt - 1'b1;
            end
            WAIT_DROP: begin
                if (vend_sense) begin
                    nxt     = (coins != 2'd0) ? COIN : IDLE;
                    cnt_nxt = H_LOAD;
                end
`ifdef VEND_DISPENSE_TIMEOUT_EN
                else if (cnt == '0) nxt = FAULT;
                else cnt_nxt = cnt - 1'b1;
`endif
            end
            COIN: begin
                if (cnt == '0) begin
                    nxt     = WAIT_COIN;
                    cnt_nxt = T_LOAD;
                end else cnt_nxt = cnt - 1'b1;
            end
            WAIT_COIN: begin
                if (coin_sense) begin
                    coins_nxt = coins - 1'b1;
                    nxt       = (coins != 2'd1) ? COIN : IDLE;
                    cnt_nxt   = H_LOAD;
                end
`ifdef VEND_DISPENSE_TIMEOUT_EN
                else if (cnt == '0) nxt = FAULT;
                else cnt_nxt = cnt - 1'b1;
`endif
            end
            FAULT: begin
                if (fault_clr) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // State register and outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            coins        <= '0;
            vend_motor   <= 1'b0;
            hopper_pulse <= 1'b0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= nxt;
            cnt          <= cnt_nxt;
            coins        <= coins_nxt;
            vend_motor   <= (nxt == VEND);
            hopper_pulse <= (nxt == COIN);
            busy         <= (nxt != IDLE) || (q_count_nxt != '0);
            overflow     <= fault_clr ? 1'b0 : (overflow || (beverage && !q_accepted));
        end
    end

`ifdef VEND_DISPENSE_TIMEOUT_EN
    // Fault flag tracks the FAULT state one register stage after the decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault <= 1'b0;
        else        fault <= (nxt == FAULT);
    end
`else
    assign fault = 1'b0;
`endif

endmodule
